// File: rtl/memory_pkg.sv
// Shared storage-element constants: default register width and reset-value pattern,
// reused by the flip-flop unit and the register-file blocks.
package memory_pkg;

  localparam int   DEFAULT_WIDTH     = 1;
  localparam logic DEFAULT_RESET_BIT = 1'b0;

endpackage

// File: rtl/d_flip_flop_unit_latch.sv
// Level-sensitive D latch: transparent while i_gate is high, holds while i_gate is low.
// Used as the master and slave halves of each flip-flop bit slice.
module d_latch (
  input  logic i_gate,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  always_latch begin
    if (i_gate) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/d_flip_flop_unit.sv
// Rising-edge D register with synchronous active-high reset and load enable, built from
// master-slave latch pairs. Optional macro D_FLIP_FLOP_QN_EN adds the qn = ~q output.
module d_flip_flop_unit
  import memory_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{DEFAULT_RESET_BIT}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
`ifdef D_FLIP_FLOP_QN_EN
  ,
  output logic [WIDTH-1:0] qn
`endif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic w_next;
    logic w_master;

    // Reset and enable are resolved ahead of the master, so they only act through the
    // value the master holds when clk rises: both are synchronous by construction.
    assign w_next = rst ? RESET_VALUE[i] : (en ? d[i] : q[i]);

    d_latch u_master (
      .i_gate (~clk),
      .i_d    (w_next),
      .o_q    (w_master)
    );

    d_latch u_slave (
      .i_gate (clk),
      .i_d    (w_master),
      .o_q    (q[i])
    );

`ifdef D_FLIP_FLOP_QN_EN
    // Separate slave fed from the same master so qn updates on exactly the same edge.
    d_latch u_slave_n (
      .i_gate (clk),
      .i_d    (~w_master),
      .o_q    (qn[i])
    );
`endif
  end

endmodule

// File: tb/tb_d_flip_flop_unit.sv
// Self-checking bench for d_flip_flop_unit: fixed vector table, hand-written edge/reset
// corner sequences, glitch rejection on a 1-bit instance and randomized model checking.
module tb_d_flip_flop_unit;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] d;
    logic [7:0] expQ;
    logic [7:0] expQ81;
  } vector_t;

  logic       clk = 1'b0;
  logic       rst1, en1, d1, q1;
  logic       rst8, en8;
  logic [7:0] d8, q8, q81;
`ifdef D_FLIP_FLOP_QN_EN
  logic       qn1;
  logic [7:0] qn8, qn81;
`endif

  int         nVectors     = 0;
  int         nMiscompares = 0;
  logic [7:0] model0;
  logic [7:0] model81;
  logic       glitchDone;
  vector_t    vectors[10];

  // Period 6, first rising edge at t=3.
  always #3 clk = ~clk;

  d_flip_flop_unit #(.WIDTH(1)) u_dut1 (
    .clk (clk), .rst (rst1), .en (en1), .d (d1), .q (q1)
`ifdef D_FLIP_FLOP_QN_EN
    , .qn (qn1)
`endif
  );

  d_flip_flop_unit #(.WIDTH(8)) u_dut8 (
    .clk (clk), .rst (rst8), .en (en8), .d (d8), .q (q8)
`ifdef D_FLIP_FLOP_QN_EN
    , .qn (qn8)
`endif
  );

  d_flip_flop_unit #(.WIDTH(8), .RESET_VALUE(8'h81)) u_dut81 (
    .clk (clk), .rst (rst8), .en (en8), .d (d8), .q (q81)
`ifdef D_FLIP_FLOP_QN_EN
    , .qn (qn81)
`endif
  );

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkAll(input string tag, input logic [7:0] exp0, input logic [7:0] exp81);
    checkOutput({tag, " q"}, q8, exp0);
    checkOutput({tag, " q(rv81)"}, q81, exp81);
`ifdef D_FLIP_FLOP_QN_EN
    checkOutput({tag, " qn"}, qn8, ~exp0);
    checkOutput({tag, " qn(rv81)"}, qn81, ~exp81);
`endif
  endtask

  task automatic checkBit(input string tag, input logic expBit);
    checkOutput({tag, " q1"}, {7'b0, q1}, {7'b0, expBit});
`ifdef D_FLIP_FLOP_QN_EN
    checkOutput({tag, " qn1"}, {7'b0, qn1}, {7'b0, ~expBit});
`endif
  endtask

  // Inputs change in the low phase; the reference model applies the register rule
  // at the rising edge, and the caller checks one time unit after that edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [7:0] dv);
    @(negedge clk);
    #1;
    rst8 = r;
    en8  = e;
    d8   = dv;
    @(posedge clk);
    if (r) begin
      model0  = 8'h00;
      model81 = 8'h81;
    end else if (e) begin
      model0  = dv;
      model81 = dv;
    end
    #1;
  endtask

  task automatic applyBitStimulus(input logic r, input logic e, input logic dv);
    @(negedge clk);
    #1;
    rst1 = r;
    en1  = e;
    d1   = dv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst1 = 1'b0; en1 = 1'b0; d1 = 1'b0;
    rst8 = 1'b0; en8 = 1'b0; d8 = 8'h00;
    glitchDone = 1'b0;

    vectors[0] = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'h81};
    vectors[1] = '{1'b0, 1'b1, 8'hA5, 8'hA5, 8'hA5};
    vectors[2] = '{1'b0, 1'b0, 8'h3C, 8'hA5, 8'hA5};
    vectors[3] = '{1'b0, 1'b0, 8'h3C, 8'hA5, 8'hA5};
    vectors[4] = '{1'b0, 1'b0, 8'h3C, 8'hA5, 8'hA5};
    vectors[5] = '{1'b0, 1'b1, 8'h3C, 8'h3C, 8'h3C};
    vectors[6] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h81};
    vectors[7] = '{1'b0, 1'b1, 8'h5A, 8'h5A, 8'h5A};
    vectors[8] = '{1'b1, 1'b1, 8'h5A, 8'h00, 8'h81};
    vectors[9] = '{1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF};

    $display("[TB] 1-bit reset and glitch rejection");
    applyBitStimulus(1'b1, 1'b1, 1'b1);
    checkBit("bit reset", 1'b0);
    applyBitStimulus(1'b0, 1'b1, 1'b1);
    fork
      begin
        int unsigned dly;
        while (!glitchDone) begin
          dly = $urandom_range(1, 2);
          if ((($time + 64'(dly)) % 6) == 3) dly = 3 - dly;
          #(dly);
          d1 = ~d1;
        end
      end
      begin
        for (int c = 0; c < 12; c++) begin
          logic expBit;
          @(posedge clk);
          expBit = d1;
          #1;
          checkBit("glitch after edge", expBit);
          #4;
          checkBit("glitch before next edge", expBit);
        end
        glitchDone = 1'b1;
      end
    join

    applyBitStimulus(1'b0, 1'b1, 1'b1);
    checkBit("bit load", 1'b1);
    @(negedge clk);
    #1;
    en1 = 1'b0; d1 = 1'b0; rst1 = 1'b1;
    #1;
    rst1 = 1'b0;
    @(posedge clk);
    #1;
    checkBit("bit rst pulse between edges", 1'b1);

    $display("[TB] 8-bit vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vectors[i].rst, vectors[i].en, vectors[i].d);
      checkAll($sformatf("table[%0d]", i), vectors[i].expQ, vectors[i].expQ81);
    end

    $display("[TB] 8-bit mid-cycle reset and falling-edge sequences");
    @(negedge clk);
    #1;
    en8 = 1'b0; d8 = 8'h00; rst8 = 1'b1;
    #1;
    rst8 = 1'b0;
    @(posedge clk);
    #1;
    checkAll("low-phase rst pulse", 8'hFF, 8'hFF);
    rst8 = 1'b1;
    #1;
    checkAll("high-phase rst assert", 8'hFF, 8'hFF);
    @(posedge clk);
    model0 = 8'h00;
    model81 = 8'h81;
    #1;
    checkAll("rst taken at next edge", 8'h00, 8'h81);

    applyStimulus(1'b0, 1'b1, 8'h11);
    checkAll("load before negedge change", 8'h11, 8'h11);
    @(negedge clk);
    d8 = 8'h22;
    #1;
    checkAll("d change at negedge", 8'h11, 8'h11);
    #1;
    checkAll("d change held to edge", 8'h11, 8'h11);
    @(posedge clk);
    model0 = 8'h22;
    model81 = 8'h22;
    #1;
    checkAll("negedge data taken at posedge", 8'h22, 8'h22);

    $display("[TB] randomized stimulus against reference model");
    for (int i = 0; i < 300; i++) begin
      logic       r;
      logic       e;
      logic [7:0] dv;
      r  = ($urandom_range(0, 9) == 0);
      e  = 1'($urandom_range(0, 1));
      dv = 8'($urandom);
      applyStimulus(r, e, dv);
      checkAll("random", model0, model81);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
